// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - control, bus and memory-side signals of the memory access unit
interface mem_access_unit_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             rw;
    logic             ld_mar;
    logic             ld_mdr;
    logic [WIDTH-1:0] bus_in;
    logic [WIDTH-1:0] mux_in;
    logic [WIDTH-1:0] mem_rdata;
    logic             mem_sel;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic             mem_ce;
    logic             mem_we;
    logic [WIDTH-1:0] mar;
    logic [WIDTH-1:0] mdr;
    logic             busy;
    logic             done;
    logic [15:0]      access_count;

    modport master (
        output start, rw, ld_mar, ld_mdr, bus_in, mux_in, mem_rdata,
        input  mem_sel, mem_addr, mem_wdata, mem_ce, mem_we, mar, mdr,
               busy, done, access_count
    );

    modport slave (
        input  start, rw, ld_mar, ld_mdr, bus_in, mux_in, mem_rdata,
        output mem_sel, mem_addr, mem_wdata, mem_ce, mem_we, mar, mdr,
               busy, done, access_count
    );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MAR/MDR memory access sequencer; MEM_ACCESS_COUNT_EN adds a transaction counter
module mem_access_unit #(
    parameter int WIDTH       = 16,
    parameter int WAIT_CYCLES = 2
) (
    input logic              clk,
    input logic              reset,
    mem_access_unit_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t           state;
    logic [3:0]       wait_cnt;
    logic             rw_q;
    logic [WIDTH-1:0] mar_q;
    logic [WIDTH-1:0] mdr_q;
    logic             mem_ce_q;
    logic             mem_we_q;
    logic             mem_sel_q;
    logic             busy_q;
    logic             done_q;

    // Outputs are registered alongside the state so they change exactly on transitions.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            wait_cnt  <= 4'd0;
            rw_q      <= 1'b0;
            mar_q     <= '0;
            mdr_q     <= '0;
            mem_ce_q  <= 1'b0;
            mem_we_q  <= 1'b0;
            mem_sel_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        rw_q      <= bus.rw;
                        wait_cnt  <= 4'(WAIT_CYCLES - 1);
                        state     <= ACCESS;
                        busy_q    <= 1'b1;
                        mem_ce_q  <= 1'b1;
                        mem_we_q  <= bus.rw;
                        mem_sel_q <= ~bus.rw;
                    end else begin
                        if (bus.ld_mar) mar_q <= bus.bus_in;
                        if (bus.ld_mdr) mdr_q <= bus.mux_in;
                    end
                end
                ACCESS: begin
                    if (wait_cnt == 4'd0) begin
                        // Mux is steered to memory during a read, so mux_in carries read data here.
                        if (!rw_q) mdr_q <= bus.mux_in;
                        state     <= DONE;
                        mem_ce_q  <= 1'b0;
                        mem_we_q  <= 1'b0;
                        mem_sel_q <= 1'b0;
                        done_q    <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    mem_ce_q  <= 1'b0;
                    mem_we_q  <= 1'b0;
                    mem_sel_q <= 1'b0;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

`ifdef MEM_ACCESS_COUNT_EN
    logic [15:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= 16'd0;
        end else if (state == DONE) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign bus.access_count = count_q;
`else
    assign bus.access_count = 16'd0;
`endif

    assign bus.mem_sel   = mem_sel_q;
    assign bus.mem_addr  = mar_q;
    assign bus.mem_wdata = mdr_q;
    assign bus.mem_ce    = mem_ce_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mar       = mar_q;
    assign bus.mdr       = mdr_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - table-driven bench for mem_access_unit with WAIT_CYCLES=2
module tb_mem_access_unit;
    logic clk;
    logic reset;

    mem_access_unit_if #(.WIDTH(16)) bus ();

    mem_access_unit #(.WIDTH(16), .WAIT_CYCLES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Upstream MDR source mux: D1 = bus, D2 = memory read data.
    assign bus.mux_in = bus.mem_sel ? bus.mem_rdata : bus.bus_in;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        st;
        logic        rw;
        logic        lmar;
        logic        lmdr;
        logic [15:0] bin;
        logic [15:0] rdata;
        logic [4:0]  flags;   // {busy, done, ce, we, sel}
        logic [15:0] mar;
        logic [15:0] mdr;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[18];
    int   n_cmp;
    int   n_bad;

    function automatic vec_t mk(logic rst, logic st, logic rw, logic lmar, logic lmdr,
                                logic [15:0] bin, logic [15:0] rdata, logic [4:0] flags,
                                logic [15:0] mar, logic [15:0] mdr, logic [15:0] cnt);
        vec_t v;
        v.rst = rst; v.st = st; v.rw = rw; v.lmar = lmar; v.lmdr = lmdr;
        v.bin = bin; v.rdata = rdata; v.flags = flags; v.mar = mar; v.mdr = mdr;
`ifdef MEM_ACCESS_COUNT_EN
        v.cnt = cnt;
`else
        v.cnt = 16'd0 & cnt;
`endif
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic st, input logic rw, input logic lmar,
                         input logic lmdr, input logic [15:0] bin, input logic [15:0] rdata);
        reset         = rst;
        bus.start     = st;
        bus.rw        = rw;
        bus.ld_mar    = lmar;
        bus.ld_mdr    = lmdr;
        bus.bus_in    = bin;
        bus.mem_rdata = rdata;
    endtask

    function automatic logic [4:0] flags_now();
        return {bus.busy, bus.done, bus.mem_ce, bus.mem_we, bus.mem_sel};
    endfunction

    initial begin
        n_cmp = 0;
        n_bad = 0;
        //            rst st rw lm ld bin       rdata     flags     mar       mdr       cnt
        vecs[0]  = mk(1, 0, 0, 0, 0, 16'h0000, 16'h0000, 5'b00000, 16'h0000, 16'h0000, 16'd0);
        vecs[1]  = mk(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 5'b00000, 16'h0000, 16'h0000, 16'd0);
        vecs[2]  = mk(0, 0, 0, 1, 0, 16'h3000, 16'h0000, 5'b00000, 16'h3000, 16'h0000, 16'd0);
        vecs[3]  = mk(0, 1, 0, 0, 0, 16'h0000, 16'hBEEF, 5'b10101, 16'h3000, 16'h0000, 16'd0);
        vecs[4]  = mk(0, 0, 0, 1, 0, 16'hFFFF, 16'hBEEF, 5'b10101, 16'h3000, 16'h0000, 16'd0);
        vecs[5]  = mk(0, 1, 0, 1, 0, 16'hFFFF, 16'hBEEF, 5'b11000, 16'h3000, 16'hBEEF, 16'd0);
        vecs[6]  = mk(0, 1, 0, 1, 0, 16'hFFFF, 16'hBEEF, 5'b00000, 16'h3000, 16'hBEEF, 16'd1);
        vecs[7]  = mk(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 5'b00000, 16'h3000, 16'hBEEF, 16'd1);
        vecs[8]  = mk(0, 0, 0, 0, 1, 16'h1234, 16'h0000, 5'b00000, 16'h3000, 16'h1234, 16'd1);
        vecs[9]  = mk(0, 1, 1, 1, 1, 16'h5555, 16'hAAAA, 5'b10110, 16'h3000, 16'h1234, 16'd1);
        vecs[10] = mk(0, 0, 0, 0, 0, 16'h0000, 16'hAAAA, 5'b10110, 16'h3000, 16'h1234, 16'd1);
        vecs[11] = mk(0, 0, 0, 0, 0, 16'h0000, 16'hAAAA, 5'b11000, 16'h3000, 16'h1234, 16'd1);
        vecs[12] = mk(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 5'b00000, 16'h3000, 16'h1234, 16'd2);
        vecs[13] = mk(0, 0, 0, 1, 1, 16'h0A0A, 16'hCCCC, 5'b00000, 16'h0A0A, 16'h0A0A, 16'd2);
        vecs[14] = mk(0, 1, 0, 0, 0, 16'h0000, 16'h1111, 5'b10101, 16'h0A0A, 16'h0A0A, 16'd2);
        vecs[15] = mk(0, 0, 0, 0, 0, 16'h0000, 16'h1111, 5'b10101, 16'h0A0A, 16'h0A0A, 16'd2);
        vecs[16] = mk(1, 0, 0, 0, 0, 16'h0000, 16'h1111, 5'b00000, 16'h0000, 16'h0000, 16'd0);
        vecs[17] = mk(0, 0, 0, 0, 0, 16'h0000, 16'h1111, 5'b00000, 16'h0000, 16'h0000, 16'd0);

        drive(1, 0, 0, 0, 0, 16'h0, 16'h0);
        @(posedge clk);
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].st, vecs[i].rw, vecs[i].lmar, vecs[i].lmdr,
                  vecs[i].bin, vecs[i].rdata);
            @(posedge clk);
            #1;
            check($sformatf("row%0d flags", i), 16'(flags_now()), 16'(vecs[i].flags));
            check($sformatf("row%0d mar", i), bus.mar, vecs[i].mar);
            check($sformatf("row%0d mdr", i), bus.mdr, vecs[i].mdr);
            check($sformatf("row%0d mem_addr", i), bus.mem_addr, vecs[i].mar);
            check($sformatf("row%0d mem_wdata", i), bus.mem_wdata, vecs[i].mdr);
            check($sformatf("row%0d access_count", i), bus.access_count, vecs[i].cnt);
        end

        // Latency: done must appear exactly two edges after start and last one cycle.
        begin
            int cyc;
            int done_at;
            int done_len;
            @(negedge clk);
            drive(0, 1, 1, 0, 0, 16'h0, 16'h0);
            @(posedge clk);
            #1;
            drive(0, 0, 0, 0, 0, 16'h0, 16'h0);
            done_at  = -1;
            done_len = 0;
            for (cyc = 1; cyc <= 8; cyc++) begin
                @(posedge clk);
                #1;
                if (bus.mem_we && !bus.mem_ce) check("we_without_ce", 16'd1, 16'd0);
                if (bus.done) begin
                    done_len++;
                    if (done_at < 0) done_at = cyc;
                end
            end
            check("latency_done_edges", 16'(done_at), 16'd2);
            check("done_pulse_len", 16'(done_len), 16'd1);
            check("busy_after_txn", 16'(bus.busy), 16'd0);
        end

`ifdef MEM_ACCESS_COUNT_EN
        // Counter wrap from 16'hFFFF to 0 on one more transaction.
        @(negedge clk);
        force dut.count_q = 16'hFFFF;
        #1;
        release dut.count_q;
        check("count_preload", bus.access_count, 16'hFFFF);
        drive(0, 1, 0, 0, 0, 16'h0, 16'h0);
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0, 16'h0, 16'h0);
        repeat (3) @(posedge clk);
        #1;
        check("count_wrap", bus.access_count, 16'h0000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
